// File: rtl/id_stage_ctrl_pkg.sv
// Shared definitions for the decode-stage controller: format codes, opcode
// constants, FSM state encoding and the held-entry record.
// Optional feature macro: ID_SKID_BUF_EN (adds the SKID state).
package id_stage_ctrl_pkg;

  // Instruction format codes presented on OUT_TYPE
  localparam logic [31:0] FMT_R = 32'd0;
  localparam logic [31:0] FMT_I = 32'd1;
  localparam logic [31:0] FMT_S = 32'd2;
  localparam logic [31:0] FMT_B = 32'd3;
  localparam logic [31:0] FMT_U = 32'd4;
  localparam logic [31:0] FMT_J = 32'd5;

  // Major opcodes, INS[6:0]
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1
`ifdef ID_SKID_BUF_EN
    ,
    ST_SKID  = 2'd2
`endif
  } state_e;

  // One decoded instruction as held by the stage
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] fmt;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  // Idle-output value: the configured NOP, classified as I with zero immediate
  function automatic entry_t idle_entry(input logic [31:0] nop_ins);
    entry_t e;
    e.ins     = nop_ins;
    e.pc      = 32'd0;
    e.fmt     = FMT_I;
    e.imm     = 32'd0;
    e.illegal = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/id_stage_ctrl_opcode_classifier.sv
// Purpose: combinational opcode classifier; maps an instruction word to its
//   format code, illegal flag and sign/zero-extended immediate.
// Ports: ins_i (instruction) -> type_o (format code), illegal_o, imm_o.
module opcode_classifier
  import id_stage_ctrl_pkg::*;
(
  input  logic [31:0] ins_i,
  output logic [31:0] type_o,
  output logic        illegal_o,
  output logic [31:0] imm_o
);

  logic [31:0] imm_i_fmt;
  logic [31:0] imm_s_fmt;
  logic [31:0] imm_b_fmt;
  logic [31:0] imm_u_fmt;
  logic [31:0] imm_j_fmt;

  assign imm_i_fmt = {{21{ins_i[31]}}, ins_i[30:20]};
  assign imm_s_fmt = {{21{ins_i[31]}}, ins_i[30:25], ins_i[11:7]};
  assign imm_b_fmt = {{20{ins_i[31]}}, ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
  assign imm_u_fmt = {ins_i[31:12], 12'b0};
  assign imm_j_fmt = {{12{ins_i[31]}}, ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};

  always_comb begin
    type_o    = FMT_R;
    illegal_o = 1'b0;
    imm_o     = 32'd0;
    case (ins_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        type_o = FMT_I;
        imm_o  = imm_i_fmt;
      end
      OPC_STORE: begin
        type_o = FMT_S;
        imm_o  = imm_s_fmt;
      end
      OPC_BRANCH: begin
        type_o = FMT_B;
        imm_o  = imm_b_fmt;
      end
      OPC_LUI, OPC_AUIPC: begin
        type_o = FMT_U;
        imm_o  = imm_u_fmt;
      end
      OPC_JAL: begin
        type_o = FMT_J;
        imm_o  = imm_j_fmt;
      end
      OPC_OP: begin
        type_o = FMT_R;
      end
      default: begin
        // Unknown opcode: reported as R-type with no immediate
        type_o    = FMT_R;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Purpose: decode-stage pipeline register with valid/ready handshake; classifies
//   and extends the immediate on the input path, holds one entry (two with
//   ID_SKID_BUF_EN defined, which also makes IN_READY a register output).
// Ports: CLK, RST_N (async active-low), IN_VALID/IN_READY/IN_INS/IN_PC from fetch,
//   FLUSH, OUT_VALID/OUT_READY/OUT_INS/OUT_PC/OUT_TYPE/OUT_IMM/OUT_ILLEGAL to execute.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INS = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_INS,
  input  logic [31:0] IN_PC,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_INS,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_TYPE,
  output logic [31:0] OUT_IMM,
  output logic        OUT_ILLEGAL
);

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t new_ent;
  entry_t out_ent;

  logic [31:0] cls_type;
  logic        cls_illegal;
  logic [31:0] cls_imm;
  logic        in_fire;
  logic        out_fire;

  opcode_classifier u_classifier (
    .ins_i     (IN_INS),
    .type_o    (cls_type),
    .illegal_o (cls_illegal),
    .imm_o     (cls_imm)
  );

  assign new_ent.ins     = IN_INS;
  assign new_ent.pc      = IN_PC;
  assign new_ent.fmt     = cls_type;
  assign new_ent.imm     = cls_imm;
  assign new_ent.illegal = cls_illegal;

  assign OUT_VALID = (state_q != ST_EMPTY);
  assign in_fire   = IN_VALID & IN_READY;
  assign out_fire  = OUT_VALID & OUT_READY;

`ifdef ID_SKID_BUF_EN
  entry_t skid_q, skid_d;
  logic   in_rdy_q, in_rdy_d;

  // Registered ready: high exactly when the skid slot will be free next cycle.
  // Gated by RST_N so the stage never advertises space while held in reset.
  assign IN_READY = in_rdy_q & RST_N;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = new_ent;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = new_ent;
          end else if (in_fire) begin
            state_d = ST_SKID;
            skid_d  = new_ent;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // IN_READY is low here, so only a consume can happen
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_rdy_d = (state_d != ST_SKID);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      skid_q   <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      skid_q   <= skid_d;
      in_rdy_q <= in_rdy_d;
    end
  end
`else
  // Single entry: room whenever empty or being drained this cycle
  assign IN_READY = RST_N & (~OUT_VALID | OUT_READY);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = new_ent;
          end
        end
        ST_FULL: begin
          // An accept here implies a consume, so the new word replaces the old
          if (in_fire) begin
            main_d = new_ent;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // Idle outputs show the NOP so downstream sees a harmless word when invalid
  assign out_ent     = OUT_VALID ? main_q : idle_entry(NOP_INS);
  assign OUT_INS     = out_ent.ins;
  assign OUT_PC      = out_ent.pc;
  assign OUT_TYPE    = out_ent.fmt;
  assign OUT_IMM     = out_ent.imm;
  assign OUT_ILLEGAL = out_ent.illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed testbench for id_stage_ctrl: reset values, classification and
// immediates, stall/backpressure, flush and reset during a stall.
module tb_id_stage_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INS;
  logic [31:0] IN_PC;
  logic        FLUSH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INS;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_TYPE;
  logic [31:0] OUT_IMM;
  logic        OUT_ILLEGAL;

  localparam logic [31:0] T_R = 32'd0, T_I = 32'd1, T_S = 32'd2,
                          T_B = 32'd3, T_U = 32'd4, T_J = 32'd5;
`ifdef ID_SKID_BUF_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  id_stage_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_INS     (IN_INS),
    .IN_PC      (IN_PC),
    .FLUSH      (FLUSH),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_INS    (OUT_INS),
    .OUT_PC     (OUT_PC),
    .OUT_TYPE   (OUT_TYPE),
    .OUT_IMM    (OUT_IMM),
    .OUT_ILLEGAL(OUT_ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"}, {31'd0, OUT_VALID},   32'd0);
    check({tag, "_ins"}, OUT_INS,              32'h00000013);
    check({tag, "_typ"}, OUT_TYPE,             T_I);
    check({tag, "_imm"}, OUT_IMM,              32'd0);
    check({tag, "_pc"},  OUT_PC,               32'd0);
    check({tag, "_ill"}, {31'd0, OUT_ILLEGAL}, 32'd0);
  endtask

  logic [31:0] vec_ins [4] = '{32'h00112623, 32'hFE000EE3, 32'h123452B7, 32'h0000006F};
  logic [31:0] vec_typ [4] = '{T_S, T_B, T_U, T_J};
  logic [31:0] vec_imm [4] = '{32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000000};

  logic [31:0] exp_q[$];
  logic [31:0] w;
  int          acc;
  int          idx;
  int          drained;

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; IN_INS = 32'd0; IN_PC = 32'd0;
    FLUSH = 1'b0; OUT_READY = 1'b0;

    // Reset state
    #12;
    check_idle("rst");
    check("rst_inrdy", {31'd0, IN_READY}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rel_inrdy", {31'd0, IN_READY}, 32'd1);

    // All-ones I immediate
    IN_VALID = 1'b1; IN_INS = 32'hFFF00093; IN_PC = 32'h00000100; OUT_READY = 1'b1;
    step();
    check("i_vld", {31'd0, OUT_VALID},   32'd1);
    check("i_typ", OUT_TYPE,             T_I);
    check("i_imm", OUT_IMM,              32'hFFFFFFFF);
    check("i_ill", {31'd0, OUT_ILLEGAL}, 32'd0);
    check("i_pc",  OUT_PC,               32'h00000100);

    // Back-to-back S/B/U/J, one per cycle
    for (int i = 0; i < 4; i++) begin
      IN_INS = vec_ins[i];
      IN_PC  = 32'h00000200 + 32'(i * 4);
      step();
      check($sformatf("b2b%0d_vld", i), {31'd0, OUT_VALID}, 32'd1);
      check($sformatf("b2b%0d_ins", i), OUT_INS,  vec_ins[i]);
      check($sformatf("b2b%0d_typ", i), OUT_TYPE, vec_typ[i]);
      check($sformatf("b2b%0d_imm", i), OUT_IMM,  vec_imm[i]);
      check($sformatf("b2b%0d_pc", i),  OUT_PC,   32'h00000200 + 32'(i * 4));
    end
    IN_VALID = 1'b0;
    step();
    check_idle("drain");

    // Illegal opcode
    IN_VALID = 1'b1; IN_INS = 32'h0000007F; IN_PC = 32'h00000300;
    step();
    check("ill_vld", {31'd0, OUT_VALID},   32'd1);
    check("ill_ill", {31'd0, OUT_ILLEGAL}, 32'd1);
    check("ill_typ", OUT_TYPE,             T_R);
    check("ill_imm", OUT_IMM,              32'd0);
    IN_VALID = 1'b0;
    step();
    check("ill_gone", {31'd0, OUT_VALID}, 32'd0);

    // Stall for five cycles while fetch keeps offering distinct words
    OUT_READY = 1'b0; IN_VALID = 1'b1; idx = 0; acc = 0;
    IN_INS = 32'h00100093; IN_PC = 32'h00001000;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      w = (IN_VALID && IN_READY) ? 32'd1 : 32'd0;
      step();
      if (w == 32'd1) begin
        exp_q.push_back(IN_INS);
        acc++;
        idx++;
        IN_INS = 32'h00100093 + (32'(idx) << 20);
        IN_PC  = 32'h00001000 + 32'(idx * 4);
      end
      check($sformatf("stall%0d_ins", c), OUT_INS, 32'h00100093);
      check($sformatf("stall%0d_pc", c),  OUT_PC,  32'h00001000);
    end
    check("stall_acc",   32'(acc),           32'(EXP_ACC));
    check("stall_inrdy", {31'd0, IN_READY},  32'd0);

    // Release: every accepted word comes out once, in order
    IN_VALID = 1'b0; OUT_READY = 1'b1; drained = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check($sformatf("rel%0d_ins", drained), OUT_INS, w);
        drained++;
      end
    end
    check("rel_count", 32'(drained), 32'(EXP_ACC));
    #1;
    check("rel_empty", {31'd0, OUT_VALID}, 32'd0);

    // Flush with an entry held and a live input transfer
    @(negedge CLK);
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_INS = 32'h00500093; IN_PC = 32'h00002000;
    step();
    check("fl_held", OUT_INS, 32'h00500093);
    IN_INS = 32'h0BAD0037; IN_PC = 32'h00002004; OUT_READY = 1'b1; FLUSH = 1'b1;
    step();
    check_idle("fl");
    FLUSH = 1'b0; IN_VALID = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("fl_after%0d_vld", c), {31'd0, OUT_VALID}, 32'd0);
      check($sformatf("fl_after%0d_ins", c), OUT_INS, 32'h00000013);
    end

    // Reset pulsed in the middle of a stall
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_INS = 32'h00700093; IN_PC = 32'h00003000;
    step();
    check("rs_held", {31'd0, OUT_VALID}, 32'd1);
    IN_VALID = 1'b0;
    #1;
    RST_N = 1'b0;
    #1;
    check_idle("rs_async");
    check("rs_inrdy", {31'd0, IN_READY}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rs_rel_inrdy", {31'd0, IN_READY}, 32'd1);
    step();
    check("rs_rel_vld", {31'd0, OUT_VALID}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 Parameter NOP_INS, default 32'h00000013, instruction word driven on OUT_INS while OUT_VALID=0.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 IN_VALID  input  1  fetch offers IN_INS/IN_PC.
REQ-005 IN_READY  output  1  block accepts; transfer when IN_VALID&IN_READY.
REQ-006 IN_INS  input  32  raw instruction word.
REQ-007 IN_PC  input  32  PC of IN_INS.
REQ-008 FLUSH  input  1  synchronous kill of all held entries.
REQ-009 OUT_VALID  output  1  decoded entry available.
REQ-010 OUT_READY  input  1  execute consumes; transfer when OUT_VALID&OUT_READY.
REQ-011 OUT_INS / OUT_PC  output  32 each  held instruction and PC.
REQ-012 OUT_TYPE  output  32  format code (R/I/S/B/U/J).
REQ-013 OUT_IMM  output  32  extended immediate.
REQ-014 OUT_ILLEGAL  output  1  opcode not in decode table.

Function
REQ-015 Opcode INS[6:0] SHALL classify: 0010011/0000011/1100111/1110011->I; 0100011->S; 1100011->B; 0110111/0010111->U; 1101111->J; 0110011->R; any other->R with OUT_ILLEGAL=1.
REQ-016 Immediate SHALL be formed at accept time and registered: I={21{i31},i30:20}; S={21{i31},i30:25,i11:7}; B={20{i31},i7,i30:25,i11:8,0}; U={i31:12,12'b0}; J={12{i31},i19:12,i20,i30:21,0}; R/illegal=0.
REQ-017 Latency SHALL be exactly one cycle: word accepted at edge N is on outputs with OUT_VALID=1 after edge N.
REQ-018 Output payload SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 FSM states EMPTY, FULL (and SKID when configured); EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL on simultaneous accept and consume (new word replaces old).
REQ-020 FLUSH=1 SHALL force EMPTY at next edge, dropping any same-cycle input transfer and output transfer's replacement; FLUSH has priority over every other event.
REQ-021 While OUT_VALID=0, OUT_INS SHALL equal NOP_INS, OUT_TYPE=I, OUT_IMM=0, OUT_ILLEGAL=0, OUT_PC=0.
REQ-022 Entries SHALL be delivered in acceptance order; none duplicated or lost except by FLUSH/reset.

Reset
REQ-023 RST_N=0 SHALL immediately force EMPTY, OUT_VALID=0, outputs per REQ-021, IN_READY=0 while asserted.
REQ-024 Reset release SHALL give IN_READY=1 on first cycle after deassertion; reset mid-transfer discards all held entries.

Configuration
REQ-025 Macro ID_SKID_BUF_EN defined: two-entry skid buffer, IN_READY SHALL be a register output (1 iff SKID entry empty), state SKID entered when FULL, accept, no consume; SKID->FULL on consume.
REQ-026 Macro undefined: single entry, IN_READY = !OUT_VALID | OUT_READY (combinational), no SKID state; throughput one per cycle in both builds.

Structure
REQ-027 Shared package SHALL hold format codes (R=0,I=1,S=2,B=3,U=4,J=5, 32-bit), opcode constants and the FSM state enum.
REQ-028 Sub-module opcode_classifier (combinational: INS -> TYPE, ILLEGAL, IMM) SHALL be instantiated once on the input path.

Verification
REQ-029 Accept 0xFFF00093, OUT_READY=1 -> next cycle OUT_TYPE=I, OUT_IMM=0xFFFFFFFF, OUT_ILLEGAL=0.
REQ-030 Back-to-back 0x00112623, 0xFE000EE3, 0x123452B7, 0x0000006F -> S/0x0000000C, B/0xFFFFFFFC, U/0x12345000, J/0x00000000, one per cycle in order.
REQ-031 OUT_READY=0 for 5 cycles with IN_VALID=1 -> payload stable; IN_READY drops after 1 (no macro) or 2 (macro) accepts; no loss after release.
REQ-032 FLUSH with IN_VALID=1 and entry held -> next cycle OUT_VALID=0, OUT_INS=0x00000013, flushed word never appears.
REQ-033 Accept 0x0000007F -> OUT_ILLEGAL=1, OUT_TYPE=R, OUT_IMM=0.
REQ-034 RST_N pulsed low mid-stall -> OUT_VALID=0 immediately (before next edge), IN_READY=1 first cycle after release.
